// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter
//   Shares one single-ported instruction memory between the fetch stage and
//   a program loader. After reset only the loader may access memory (BOOT);
//   once LoadDone is seen the two requesters share the port round-robin (RUN).
//   Fetch data is returned registered, one cycle after the grant.
//
// Ports
//   Clk, Reset                 clock (rising edge), async active-high reset
//   FetchReq/FetchAddr         fetch request and byte address
//   FetchGnt                   fetch granted this cycle (combinational)
//   FetchValid/FetchInstr/FetchErr  registered fetch response
//   LoadReq/LoadAddr/LoadData  loader write request, byte address, data
//   LoadGnt                    loader granted this cycle (combinational)
//   LoadDone                   loader finished, leave BOOT
//   Booted                     high in RUN
//   MemAddr/MemWrData/MemWrite/MemRdData  memory-side port
//
// Optional build macro
//   IMEM_ARB_STATS_EN  adds saturating 16-bit FetchGrantCnt, LoadGrantCnt and
//                      ConflictCnt outputs; arbitration is unaffected.

module imem_access_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 128
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  FetchReq,
   input  logic [ADDR_WIDTH-1:0] FetchAddr,
   output logic                  FetchGnt,
   output logic                  FetchValid,
   output logic [DATA_WIDTH-1:0] FetchInstr,
   output logic                  FetchErr,
   input  logic                  LoadReq,
   input  logic [ADDR_WIDTH-1:0] LoadAddr,
   input  logic [DATA_WIDTH-1:0] LoadData,
   output logic                  LoadGnt,
   input  logic                  LoadDone,
   output logic                  Booted,
   output logic [ADDR_WIDTH-3:0] MemAddr,
   output logic [DATA_WIDTH-1:0] MemWrData,
   output logic                  MemWrite,
`ifdef IMEM_ARB_STATS_EN
   output logic [15:0]           FetchGrantCnt,
   output logic [15:0]           LoadGrantCnt,
   output logic [15:0]           ConflictCnt,
`endif
   input  logic [DATA_WIDTH-1:0] MemRdData
);

   typedef enum logic {ST_BOOT, ST_RUN} state_t;
   typedef enum logic {LAST_FETCH, LAST_LOAD} last_t;

   localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_WORDS);

   state_t state;
   last_t  last_gnt;
   logic   fetch_in_range;
   logic   load_in_range;

   // Word index (byte address >> 2) must fall below MEM_WORDS.
   assign fetch_in_range = (FetchAddr >> 2) < MEM_LIMIT;
   assign load_in_range  = (LoadAddr  >> 2) < MEM_LIMIT;

   // Grant decision
   always_comb begin
      FetchGnt = 1'b0;
      LoadGnt  = 1'b0;
      if (state == ST_BOOT) begin
         LoadGnt = LoadReq;
      end else if (FetchReq && LoadReq) begin
         // Contention: favour whoever did not win last time.
         FetchGnt = (last_gnt == LAST_LOAD);
         LoadGnt  = (last_gnt == LAST_FETCH);
      end else begin
         FetchGnt = FetchReq;
         LoadGnt  = LoadReq;
      end
   end

   // Memory-side mux
   always_comb begin
      MemAddr = '0;
      if (FetchGnt)
         MemAddr = FetchAddr[ADDR_WIDTH-1:2];
      else if (LoadGnt)
         MemAddr = LoadAddr[ADDR_WIDTH-1:2];
   end

   assign MemWrData = LoadData;
   assign MemWrite  = LoadGnt && load_in_range;

   // State, round-robin history and registered fetch response
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= ST_BOOT;
         last_gnt   <= LAST_LOAD;
         Booted     <= 1'b0;
         FetchValid <= 1'b0;
         FetchErr   <= 1'b0;
         FetchInstr <= '0;
      end else begin
         case (state)
            ST_BOOT: begin
               if (LoadDone) begin
                  state  <= ST_RUN;
                  Booted <= 1'b1;
               end
            end
            ST_RUN: begin
               state  <= ST_RUN;
               Booted <= 1'b1;
            end
            default: begin
               state  <= ST_BOOT;
               Booted <= 1'b0;
            end
         endcase

         if (FetchGnt)
            last_gnt <= LAST_FETCH;
         else if (LoadGnt)
            last_gnt <= LAST_LOAD;

         if (FetchGnt) begin
            FetchValid <= 1'b1;
            FetchErr   <= !fetch_in_range;
            FetchInstr <= fetch_in_range ? MemRdData : '0;
         end else begin
            FetchValid <= 1'b0;
            FetchErr   <= 1'b0;
         end
      end
   end

`ifdef IMEM_ARB_STATS_EN
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         FetchGrantCnt <= '0;
         LoadGrantCnt  <= '0;
         ConflictCnt   <= '0;
      end else begin
         if (FetchGnt && FetchGrantCnt != 16'hFFFF)
            FetchGrantCnt <= FetchGrantCnt + 16'd1;
         if (LoadGnt && LoadGrantCnt != 16'hFFFF)
            LoadGrantCnt <= LoadGrantCnt + 16'd1;
         if (FetchReq && LoadReq && ConflictCnt != 16'hFFFF)
            ConflictCnt <= ConflictCnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_imem_access_arbiter.sv
module tb_imem_access_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 128;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic          FetchReq = 1'b0;
   logic [AW-1:0] FetchAddr = '0;
   logic          FetchGnt;
   logic          FetchValid;
   logic [DW-1:0] FetchInstr;
   logic          FetchErr;
   logic          LoadReq = 1'b0;
   logic [AW-1:0] LoadAddr = '0;
   logic [DW-1:0] LoadData = '0;
   logic          LoadGnt;
   logic          LoadDone = 1'b0;
   logic          Booted;
   logic [AW-3:0] MemAddr;
   logic [DW-1:0] MemWrData;
   logic          MemWrite;
   logic [DW-1:0] MemRdData;
`ifdef IMEM_ARB_STATS_EN
   logic [15:0]   FetchGrantCnt, LoadGrantCnt, ConflictCnt;
`endif

   imem_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW)) dut (
      .Clk(Clk), .Reset(Reset),
      .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchGnt(FetchGnt),
      .FetchValid(FetchValid), .FetchInstr(FetchInstr), .FetchErr(FetchErr),
      .LoadReq(LoadReq), .LoadAddr(LoadAddr), .LoadData(LoadData),
      .LoadGnt(LoadGnt), .LoadDone(LoadDone), .Booted(Booted),
      .MemAddr(MemAddr), .MemWrData(MemWrData), .MemWrite(MemWrite),
`ifdef IMEM_ARB_STATS_EN
      .FetchGrantCnt(FetchGrantCnt), .LoadGrantCnt(LoadGrantCnt), .ConflictCnt(ConflictCnt),
`endif
      .MemRdData(MemRdData)
   );

   always #10 Clk = ~Clk;

   // Memory attached to the DUT
   logic [DW-1:0] mem [0:MW-1];
   logic          pre_en = 1'b0;
   logic [6:0]    pre_idx = '0;
   logic [DW-1:0] pre_val = '0;

   always @(posedge Clk) begin
      if (MemWrite && MemAddr < 30'd128)
         mem[MemAddr[6:0]] <= MemWrData;
      else if (pre_en)
         mem[pre_idx] <= pre_val;
   end

   assign MemRdData = (MemAddr < 30'd128) ? mem[MemAddr[6:0]] : 32'hDEADBEEF;

   // Reference model
   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] ref_mem [0:MW-1];
   bit            m_booted;
   bit            m_last_fetch;
   logic          m_valid, m_err;
   logic [DW-1:0] m_instr;
   bit            e_fg, e_lg, e_mw;
   logic [AW-3:0] e_ma;

   function automatic bit in_rng(input logic [AW-1:0] a);
      return (a / 4) < MW;
   endfunction

   // Drive one cycle of inputs and compute expected grant/mux values.
   task automatic apply(input bit f, input logic [AW-1:0] fa, input bit l,
                        input logic [AW-1:0] la, input logic [DW-1:0] ld, input bit dn);
      FetchReq = f; FetchAddr = fa; LoadReq = l; LoadAddr = la; LoadData = ld; LoadDone = dn;
      if (!m_booted) begin
         e_fg = 1'b0; e_lg = l;
      end else if (f && l) begin
         e_fg = !m_last_fetch; e_lg = m_last_fetch;
      end else begin
         e_fg = f; e_lg = l;
      end
      e_mw = e_lg && in_rng(la);
      e_ma = e_fg ? fa[AW-1:2] : (e_lg ? la[AW-1:2] : '0);
      #1;
   endtask

   // Advance one clock edge, updating the model, and land on the falling edge.
   task automatic tick();
      @(posedge Clk);
      if (e_fg) begin
         m_valid = 1'b1;
         m_err   = !in_rng(FetchAddr);
         m_instr = m_err ? '0 : ref_mem[FetchAddr[8:2]];
      end else begin
         m_valid = 1'b0;
         m_err   = 1'b0;
      end
      if (e_lg && in_rng(LoadAddr)) ref_mem[LoadAddr[8:2]] = LoadData;
      if (e_fg || e_lg) m_last_fetch = e_fg;
      if (!m_booted && LoadDone) m_booted = 1'b1;
      @(negedge Clk);
   endtask

   task automatic assert_reset();
      Reset = 1'b1;
      m_booted = 1'b0; m_last_fetch = 1'b0;
      m_valid = 1'b0; m_err = 1'b0; m_instr = '0;
      #1;
   endtask

   task automatic release_reset();
      #1; Reset = 1'b0; #1;
   endtask

   task automatic reset_dut();
      assert_reset();
      release_reset();
   endtask

   task automatic boot();
      apply(0, 0, 0, 0, 0, 1);
      tick();
   endtask

   task automatic test_reset();
      apply(1, 32'h4, 1, 32'h8, 32'h11111111, 0);
      tick();
      apply(1, 32'h4, 1, 32'h8, 32'h11111111, 0);
      tick();
      assert_reset();
      checks++; if (FetchGnt !== 1'b0) begin errors++; $display("FAIL reset_fgnt got %b want 0", FetchGnt); end
      checks++; if (FetchValid !== 1'b0) begin errors++; $display("FAIL reset_fvalid got %b want 0", FetchValid); end
      checks++; if (Booted !== 1'b0) begin errors++; $display("FAIL reset_booted got %b want 0", Booted); end
      checks++; if (FetchInstr !== '0) begin errors++; $display("FAIL reset_finstr got %h want 0", FetchInstr); end
      release_reset();
      apply(1, 32'h4, 1, 32'h8, 32'h22222222, 0);
      checks++; if (LoadGnt !== 1'b1) begin errors++; $display("FAIL reset_lgnt got %b want 1", LoadGnt); end
      checks++; if (FetchGnt !== 1'b0) begin errors++; $display("FAIL reset_fgnt2 got %b want 0", FetchGnt); end
      tick();
      checks++; if (FetchValid !== 1'b0) begin errors++; $display("FAIL reset_fvalid2 got %b want 0", FetchValid); end
   endtask

   task automatic test_boot_load_fetch();
      reset_dut();
      apply(0, 0, 1, 32'h0, 32'h20080005, 0);
      checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL boot_memwrite got %b want 1", MemWrite); end
      checks++; if (MemAddr !== '0) begin errors++; $display("FAIL boot_memaddr got %h want 0", MemAddr); end
      tick();
      apply(0, 0, 0, 0, 0, 1);
      tick();
      checks++; if (Booted !== 1'b1) begin errors++; $display("FAIL boot_booted got %b want 1", Booted); end
      apply(1, 32'h0, 0, 0, 0, 0);
      checks++; if (FetchGnt !== 1'b1) begin errors++; $display("FAIL boot_fgnt got %b want 1", FetchGnt); end
      tick();
      checks++; if (FetchValid !== 1'b1) begin errors++; $display("FAIL boot_fvalid got %b want 1", FetchValid); end
      checks++; if (FetchInstr !== 32'h20080005) begin errors++; $display("FAIL boot_finstr got %h want 20080005", FetchInstr); end
      checks++; if (FetchErr !== 1'b0) begin errors++; $display("FAIL boot_ferr got %b want 0", FetchErr); end
   endtask

   task automatic test_boot_fetch_blocked();
      reset_dut();
      for (int i = 0; i < 5; i++) begin
         apply(1, 32'h40, 0, 0, 0, 0);
         checks++; if (FetchGnt !== 1'b0) begin errors++; $display("FAIL blocked_fgnt[%0d] got %b want 0", i, FetchGnt); end
         tick();
         checks++; if (FetchValid !== 1'b0) begin errors++; $display("FAIL blocked_fvalid[%0d] got %b want 0", i, FetchValid); end
      end
   endtask

   task automatic test_round_robin();
      logic [DW-1:0] wd;
      reset_dut();
      boot();
      // Fetch and load target the same word: the second fetch must see the write.
      for (int i = 0; i < 4; i++) begin
         bit exp_f;
         exp_f = (i % 2 == 0);
         wd = 32'hA5000000 + 32'(i);
         apply(1, 32'h10, 1, 32'h10, wd, 0);
         checks++; if (FetchGnt !== exp_f) begin errors++; $display("FAIL rr_fgnt[%0d] got %b want %b", i, FetchGnt, exp_f); end
         checks++; if (LoadGnt !== !exp_f) begin errors++; $display("FAIL rr_lgnt[%0d] got %b want %b", i, LoadGnt, !exp_f); end
         tick();
         checks++; if (FetchValid !== exp_f) begin errors++; $display("FAIL rr_fvalid[%0d] got %b want %b", i, FetchValid, exp_f); end
         if (i == 0) begin
            checks++; if (FetchInstr !== m_instr) begin errors++; $display("FAIL rr_finstr0 got %h want %h", FetchInstr, m_instr); end
         end
         if (i == 2) begin
            checks++; if (FetchInstr !== 32'hA5000001) begin errors++; $display("FAIL rr_finstr2 got %h want a5000001", FetchInstr); end
         end
      end
   endtask

   task automatic test_out_of_range();
      reset_dut();
      boot();
      apply(1, 32'h200, 0, 0, 0, 0);
      tick();
      checks++; if (FetchValid !== 1'b1) begin errors++; $display("FAIL oor_fvalid got %b want 1", FetchValid); end
      checks++; if (FetchInstr !== '0) begin errors++; $display("FAIL oor_finstr got %h want 0", FetchInstr); end
      checks++; if (FetchErr !== 1'b1) begin errors++; $display("FAIL oor_ferr got %b want 1", FetchErr); end
      apply(0, 0, 1, 32'h204, 32'hCAFEF00D, 0);
      checks++; if (LoadGnt !== 1'b1) begin errors++; $display("FAIL oor_lgnt got %b want 1", LoadGnt); end
      checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL oor_memwrite got %b want 0", MemWrite); end
      tick();
      checks++; if (FetchErr !== 1'b0) begin errors++; $display("FAIL oor_ferr2 got %b want 0", FetchErr); end
      apply(0, 0, 1, 32'h1FC, 32'h0BADC0DE, 0);
      checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL edge_memwrite got %b want 1", MemWrite); end
      checks++; if (MemAddr !== 30'd127) begin errors++; $display("FAIL edge_memaddr got %h want 7f", MemAddr); end
      tick();
   endtask

   task automatic test_reset_during_valid();
      reset_dut();
      boot();
      apply(1, 32'h8, 0, 0, 0, 0);
      tick();
      checks++; if (FetchValid !== 1'b1) begin errors++; $display("FAIL rdv_fvalid got %b want 1", FetchValid); end
      checks++; if (FetchInstr !== m_instr) begin errors++; $display("FAIL rdv_finstr got %h want %h", FetchInstr, m_instr); end
      assert_reset();
      checks++; if (FetchValid !== 1'b0) begin errors++; $display("FAIL rdv_rst_fvalid got %b want 0", FetchValid); end
      checks++; if (FetchInstr !== '0) begin errors++; $display("FAIL rdv_rst_finstr got %h want 0", FetchInstr); end
      checks++; if (Booted !== 1'b0) begin errors++; $display("FAIL rdv_rst_booted got %b want 0", Booted); end
      release_reset();
      apply(1, 32'h8, 0, 0, 0, 0);
      checks++; if (FetchGnt !== 1'b0) begin errors++; $display("FAIL rdv_boot_fgnt got %b want 0", FetchGnt); end
      tick();
   endtask

   task automatic test_random();
      bit            f, l, dn;
      logic [AW-1:0] fa, la;
      logic [DW-1:0] ld;
      f = 0; l = 0; fa = '0; la = '0; ld = '0;
      reset_dut();
      for (int n = 0; n < 600; n++) begin
         if (n == 300) begin
            reset_dut();
            f = 0; l = 0;
         end
         if (!f) begin
            if ($urandom_range(0, 9) < 6) begin f = 1; fa = $urandom_range(0, 32'h23F); end
         end else if ($urandom_range(0, 19) == 0) f = 0;
         if (!l) begin
            if ($urandom_range(0, 9) < 6) begin l = 1; la = $urandom_range(0, 32'h23F); ld = $urandom; end
         end else if ($urandom_range(0, 19) == 0) l = 0;
         dn = (n % 300 > 20) && ($urandom_range(0, 24) == 0);
         apply(f, fa, l, la, ld, dn);
         checks++; if (FetchGnt !== e_fg) begin errors++; $display("FAIL rnd_fgnt[%0d] got %b want %b", n, FetchGnt, e_fg); end
         checks++; if (LoadGnt !== e_lg) begin errors++; $display("FAIL rnd_lgnt[%0d] got %b want %b", n, LoadGnt, e_lg); end
         checks++; if (MemWrite !== e_mw) begin errors++; $display("FAIL rnd_memwrite[%0d] got %b want %b", n, MemWrite, e_mw); end
         checks++; if (MemAddr !== e_ma) begin errors++; $display("FAIL rnd_memaddr[%0d] got %h want %h", n, MemAddr, e_ma); end
         tick();
         if (e_fg) f = 0;
         if (e_lg) l = 0;
         checks++; if (FetchValid !== m_valid) begin errors++; $display("FAIL rnd_fvalid[%0d] got %b want %b", n, FetchValid, m_valid); end
         checks++; if (FetchErr !== m_err) begin errors++; $display("FAIL rnd_ferr[%0d] got %b want %b", n, FetchErr, m_err); end
         checks++; if (FetchInstr !== m_instr) begin errors++; $display("FAIL rnd_finstr[%0d] got %h want %h", n, FetchInstr, m_instr); end
         checks++; if (Booted !== m_booted) begin errors++; $display("FAIL rnd_booted[%0d] got %b want %b", n, Booted, m_booted); end
      end
   endtask

   initial begin
      m_booted = 0; m_last_fetch = 0; m_valid = 0; m_err = 0; m_instr = '0;
      e_fg = 0; e_lg = 0; e_mw = 0; e_ma = '0;
      // Preload identical random contents into the memory and the model.
      for (int i = 0; i < MW; i++) begin
         @(negedge Clk);
         pre_en = 1'b1; pre_idx = 7'(i); pre_val = $urandom;
         ref_mem[i] = pre_val;
      end
      @(negedge Clk);
      pre_en = 1'b0;
      Reset = 1'b0;
      #1;
      test_reset();
      test_boot_load_fetch();
      test_boot_fetch_blocked();
      test_round_robin();
      test_out_of_range();
      test_reset_during_valid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
